// File: rtl/cu_pkg.sv
// ============================================================================
// Package  : cu_pkg
// Shared types, instruction field positions and constants for cu_multicycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cu_pkg;

    typedef enum logic [1:0] {
        TYPE_NOP   = 2'b00,
        TYPE_STD   = 2'b01,
        TYPE_LOAD  = 2'b10,
        TYPE_STORE = 2'b11
    } instr_type_e;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_DECODE     = 3'd1,
        ST_EXECUTE    = 3'd2,
        ST_MEM_ACCESS = 3'd3,
        ST_WRITE_BACK = 3'd4
    } state_e;

    localparam logic [3:0] OPC_RESET  = 4'hF;
    localparam int         OPC_WIDTH  = 4;
    localparam int         TYPE_WIDTH = 2;

    function automatic int f_reg_bits(input int num_regs);
        return $clog2(num_regs);
    endfunction

    // Word layout, MSB first: type, rd, rs1, rs2, offset, opcode
    function automatic int f_instr_width(input int data_width, input int num_regs);
        return TYPE_WIDTH + 3 * f_reg_bits(num_regs) + data_width + OPC_WIDTH;
    endfunction

    function automatic int f_type_lsb(input int data_width, input int num_regs);
        return f_instr_width(data_width, num_regs) - TYPE_WIDTH;
    endfunction

    function automatic int f_rd_lsb(input int data_width, input int num_regs);
        return OPC_WIDTH + data_width + 2 * f_reg_bits(num_regs);
    endfunction

    function automatic int f_rs1_lsb(input int data_width, input int num_regs);
        return OPC_WIDTH + data_width + f_reg_bits(num_regs);
    endfunction

    function automatic int f_rs2_lsb(input int data_width);
        return OPC_WIDTH + data_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cu_regfile.sv
// ============================================================================
// Module   : cu_regfile
// Register file, two asynchronous reads, one synchronous write, reset to index.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cu_regfile
    import cu_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REGS   = 4,
    localparam int REG_BITS   = f_reg_bits(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_BITS-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [REG_BITS-1:0]   raddr1,
    input  logic [REG_BITS-1:0]   raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);

    logic [DATA_WIDTH-1:0] r_mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_mem_d [NUM_REGS];

    always_comb begin
        w_mem_d = r_mem_q;
        if (we) begin
            w_mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem_q[i] <= DATA_WIDTH'(i);
            end
        end else begin
            r_mem_q <= w_mem_d;
        end
    end

    assign rdata1 = r_mem_q[raddr1];
    assign rdata2 = r_mem_q[raddr2];

endmodule

`default_nettype wire

// File: rtl/cu_multicycle.sv
// ============================================================================
// Module   : cu_multicycle
// Multi-cycle control unit; CU_PERF_CNT_EN adds retired/stall counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cu_multicycle
    import cu_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int NUM_REGS    = 4,
    localparam int REG_BITS    = f_reg_bits(NUM_REGS),
    localparam int INSTR_WIDTH = f_instr_width(DATA_WIDTH, NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [DATA_WIDTH-1:0]  result2,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic [DATA_WIDTH-1:0]  operand1,
    output logic [DATA_WIDTH-1:0]  operand2,
    output logic [DATA_WIDTH-1:0]  offset,
    output logic [3:0]             opcode,
    output logic                   sel1,
    output logic                   sel3,
    output logic                   w_r,
`ifdef CU_PERF_CNT_EN
    output logic [31:0]            retired_cnt,
    output logic [31:0]            stall_cnt,
`endif
    output logic                   busy
);

    localparam int C_TYPE_LSB = f_type_lsb(DATA_WIDTH, NUM_REGS);
    localparam int C_RD_LSB   = f_rd_lsb(DATA_WIDTH, NUM_REGS);
    localparam int C_RS1_LSB  = f_rs1_lsb(DATA_WIDTH, NUM_REGS);
    localparam int C_RS2_LSB  = f_rs2_lsb(DATA_WIDTH);
    localparam int C_OFF_LSB  = OPC_WIDTH;

    localparam logic [2:0] C_ST_FETCH = ST_FETCH;
    localparam logic [2:0] C_ST_DEC   = ST_DECODE;
    localparam logic [2:0] C_ST_EXE   = ST_EXECUTE;
    localparam logic [2:0] C_ST_MEM   = ST_MEM_ACCESS;
    localparam logic [2:0] C_ST_WB    = ST_WRITE_BACK;

    logic [2:0]             r_state_q,    w_state_d;
    logic [INSTR_WIDTH-1:0] r_instr_q,    w_instr_d;
    logic [DATA_WIDTH-1:0]  r_operand1_q, w_operand1_d;
    logic [DATA_WIDTH-1:0]  r_operand2_q, w_operand2_d;
    logic [DATA_WIDTH-1:0]  r_offset_q,   w_offset_d;
    logic [3:0]             r_opcode_q,   w_opcode_d;
    logic                   r_sel1_q,     w_sel1_d;
    logic                   r_sel3_q,     w_sel3_d;

    logic [1:0]             w_type;
    logic [REG_BITS-1:0]    w_rd;
    logic [REG_BITS-1:0]    w_rs1;
    logic [REG_BITS-1:0]    w_rs2;
    logic [REG_BITS-1:0]    w_raddr2;
    logic [DATA_WIDTH-1:0]  w_rdata1;
    logic [DATA_WIDTH-1:0]  w_rdata2;
    logic                   w_we;

    assign w_type   = r_instr_q[C_TYPE_LSB +: TYPE_WIDTH];
    assign w_rd     = r_instr_q[C_RD_LSB   +: REG_BITS];
    assign w_rs1    = r_instr_q[C_RS1_LSB  +: REG_BITS];
    assign w_rs2    = r_instr_q[C_RS2_LSB  +: REG_BITS];
    // Memory-type instructions read their data register through port 2
    assign w_raddr2 = (w_type == TYPE_STD) ? w_rs2 : w_rd;

    cu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (w_we),
        .waddr  (w_rd),
        .wdata  (result2),
        .raddr1 (w_rs1),
        .raddr2 (w_raddr2),
        .rdata1 (w_rdata1),
        .rdata2 (w_rdata2)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_instr_d    = r_instr_q;
        w_operand1_d = r_operand1_q;
        w_operand2_d = r_operand2_q;
        w_offset_d   = r_offset_q;
        w_opcode_d   = r_opcode_q;
        w_sel1_d     = r_sel1_q;
        w_sel3_d     = r_sel3_q;
        w_we         = 1'b0;
        case (r_state_q)
            C_ST_FETCH: begin
                if (instr_valid) begin
                    w_instr_d = instr;
                    w_state_d = C_ST_DEC;
                end
            end
            C_ST_DEC: begin
                if (w_type == TYPE_NOP) begin
                    w_state_d = C_ST_FETCH;
                end else begin
                    w_operand1_d = w_rdata1;
                    w_operand2_d = w_rdata2;
                    w_offset_d   = r_instr_q[C_OFF_LSB +: DATA_WIDTH];
                    w_opcode_d   = r_instr_q[0 +: OPC_WIDTH];
                    w_sel1_d     = (w_type != TYPE_LOAD);
                    w_sel3_d     = (w_type != TYPE_STD);
                    w_state_d    = C_ST_EXE;
                end
            end
            C_ST_EXE: begin
                w_state_d = (w_type == TYPE_STD) ? C_ST_WB : C_ST_MEM;
            end
            C_ST_MEM: begin
                if (mem_ready) begin
                    w_state_d = (w_type == TYPE_LOAD) ? C_ST_WB : C_ST_FETCH;
                end
            end
            C_ST_WB: begin
                w_we      = 1'b1;
                w_state_d = C_ST_FETCH;
            end
            default: begin
                w_state_d    = C_ST_FETCH;
                w_operand1_d = '0;
                w_operand2_d = '0;
                w_offset_d   = '0;
                w_opcode_d   = OPC_RESET;
                w_sel1_d     = 1'b0;
                w_sel3_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= C_ST_FETCH;
            r_instr_q    <= '0;
            r_operand1_q <= '0;
            r_operand2_q <= '0;
            r_offset_q   <= '0;
            r_opcode_q   <= OPC_RESET;
            r_sel1_q     <= 1'b0;
            r_sel3_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_instr_q    <= w_instr_d;
            r_operand1_q <= w_operand1_d;
            r_operand2_q <= w_operand2_d;
            r_offset_q   <= w_offset_d;
            r_opcode_q   <= w_opcode_d;
            r_sel1_q     <= w_sel1_d;
            r_sel3_q     <= w_sel3_d;
        end
    end

    assign instr_ready = (r_state_q == C_ST_FETCH);
    assign busy        = ~instr_ready;
    assign mem_req     = (r_state_q == C_ST_MEM);
    assign w_r         = mem_req && (w_type == TYPE_STORE);
    assign operand1    = r_operand1_q;
    assign operand2    = r_operand2_q;
    assign offset      = r_offset_q;
    assign opcode      = r_opcode_q;
    assign sel1        = r_sel1_q;
    assign sel3        = r_sel3_q;

`ifdef CU_PERF_CNT_EN
    logic [31:0] r_retired_cnt_q, w_retired_cnt_d;
    logic [31:0] r_stall_cnt_q,   w_stall_cnt_d;
    logic        w_retire;

    always_comb begin
        w_retire = ((r_state_q == C_ST_DEC) && (w_type == TYPE_NOP))
                || ((r_state_q == C_ST_MEM) && mem_ready && (w_type == TYPE_STORE))
                || (r_state_q == C_ST_WB);
        w_retired_cnt_d = r_retired_cnt_q;
        w_stall_cnt_d   = r_stall_cnt_q;
        if (w_retire) begin
            w_retired_cnt_d = r_retired_cnt_q + 32'd1;
        end
        if ((r_state_q == C_ST_MEM) && !mem_ready) begin
            w_stall_cnt_d = r_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_cnt_q <= '0;
            r_stall_cnt_q   <= '0;
        end else begin
            r_retired_cnt_q <= w_retired_cnt_d;
            r_stall_cnt_q   <= w_stall_cnt_d;
        end
    end

    assign retired_cnt = r_retired_cnt_q;
    assign stall_cnt   = r_stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cu_multicycle.sv
// ============================================================================
// Module   : tb_cu_multicycle
// Directed self-checking bench for cu_multicycle (8-bit/4-reg and 16-bit/8-reg).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cu_multicycle;

    logic        clk;
    logic        rst;
    logic [19:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  result2;
    logic        mem_ready;
    logic        mem_req;
    logic [7:0]  operand1, operand2, offset;
    logic [3:0]  opcode;
    logic        sel1, sel3, w_r, busy;

    logic [30:0] x_instr;
    logic        x_valid, x_ready, x_mem_ready, x_mem_req;
    logic [15:0] x_result2, x_operand1, x_operand2, x_offset;
    logic [3:0]  x_opcode;
    logic        x_sel1, x_sel3, x_w_r, x_busy;

`ifdef CU_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt, x_retired, x_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cu_multicycle dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .result2(result2), .mem_ready(mem_ready),
        .mem_req(mem_req), .operand1(operand1), .operand2(operand2),
        .offset(offset), .opcode(opcode), .sel1(sel1), .sel3(sel3), .w_r(w_r),
`ifdef CU_PERF_CNT_EN
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
        .busy(busy)
    );

    cu_multicycle #(.DATA_WIDTH(16), .NUM_REGS(8)) dut16 (
        .clk(clk), .rst(rst), .instr(x_instr), .instr_valid(x_valid),
        .instr_ready(x_ready), .result2(x_result2), .mem_ready(x_mem_ready),
        .mem_req(x_mem_req), .operand1(x_operand1), .operand2(x_operand2),
        .offset(x_offset), .opcode(x_opcode), .sel1(x_sel1), .sel3(x_sel3), .w_r(x_w_r),
`ifdef CU_PERF_CNT_EN
        .retired_cnt(x_retired), .stall_cnt(x_stall),
`endif
        .busy(x_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [19:0] mk(input logic [1:0] t, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2,
                                       input logic [7:0] off, input logic [3:0] opc);
        return {t, rd, rs1, rs2, off, opc};
    endfunction

    function automatic logic [30:0] mk16(input logic [1:0] t, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2,
                                         input logic [15:0] off, input logic [3:0] opc);
        return {t, rd, rs1, rs2, off, opc};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        x_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [19:0] w);
        instr = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr = '1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        mem_ready = 1'b1;
        n_cmp++;
        if ({instr_ready, busy, mem_req, w_r, sel1, sel3} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy/busy/req/wr/s1/s3=%b want 100000",
                     {instr_ready, busy, mem_req, w_r, sel1, sel3});
        end
        n_cmp++;
        if ({operand1, operand2, offset, opcode} !== {8'h00, 8'h00, 8'h00, 4'hF}) begin
            n_err++;
            $display("FAIL reset_data: got op1=%h op2=%h off=%h opc=%h want 00 00 00 f",
                     operand1, operand2, offset, opcode);
        end
        for (int i = 0; i < 4; i++) begin
            issue(mk(2'b11, 2'(3 - i), 2'(i), 2'd0, 8'h00, 4'h0));
            tick();
            n_cmp++;
            if (operand1 !== 8'(i) || operand2 !== 8'(3 - i)) begin
                n_err++;
                $display("FAIL reset_regs[%0d]: got op1=%h op2=%h want %h %h",
                         i, operand1, operand2, 8'(i), 8'(3 - i));
            end
            wait_idle(n);
        end
    endtask

    task automatic test_std_op();
        int n;
        do_reset();
        mem_ready = 1'b0;
        result2 = 8'h05;
        issue(mk(2'b01, 2'd1, 2'd2, 2'd3, 8'h05, 4'h2));
        tick();
        n_cmp++;
        if ({operand1, operand2, offset, opcode, sel1, sel3} !== {8'd2, 8'd3, 8'h05, 4'h2, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL std_exec: got op1=%h op2=%h off=%h opc=%h s1=%b s3=%b want 02 03 05 2 1 0",
                     operand1, operand2, offset, opcode, sel1, sel3);
        end
        n_cmp++;
        if (busy !== 1'b1 || instr_ready !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL std_busy: got busy=%b rdy=%b req=%b want 1 0 0", busy, instr_ready, mem_req);
        end
        wait_idle(n);
        n_cmp++;
        if (1 + n !== 3) begin
            n_err++;
            $display("FAIL std_latency: got %0d want 3", 1 + n);
        end
        result2 = 8'h33;
        issue(mk(2'b01, 2'd2, 2'd1, 2'd0, 8'h00, 4'h1));
        tick();
        n_cmp++;
        if (operand1 !== 8'h05 || operand2 !== 8'h00) begin
            n_err++;
            $display("FAIL std_forward: got op1=%h op2=%h want 05 00", operand1, operand2);
        end
        wait_idle(n);
    endtask

    task automatic test_load_stall();
        int cyc, mcnt, n;
        logic wr_seen;
        do_reset();
        mem_ready = 1'b0;
        result2 = 8'hAA;
        issue(mk(2'b10, 2'd0, 2'd2, 2'd0, 8'h10, 4'h0));
        tick();
        cyc = 1;
        n_cmp++;
        if ({operand1, operand2, offset, sel1, sel3} !== {8'd2, 8'd0, 8'h10, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL load_exec: got op1=%h op2=%h off=%h s1=%b s3=%b want 02 00 10 0 1",
                     operand1, operand2, offset, sel1, sel3);
        end
        mcnt = 0;
        wr_seen = 1'b0;
        while (!instr_ready && cyc < 30) begin
            tick();
            cyc++;
            if (mem_req) begin
                mcnt++;
                if (w_r) wr_seen = 1'b1;
                if (mcnt == 4) mem_ready = 1'b1;
            end
        end
        n_cmp++;
        if (mcnt !== 4) begin
            n_err++;
            $display("FAIL load_memreq_cycles: got %0d want 4", mcnt);
        end
        n_cmp++;
        if (wr_seen !== 1'b0) begin
            n_err++;
            $display("FAIL load_w_r: got w_r=1 during load want 0");
        end
        // decode + execute + 4 memory cycles + write-back
        n_cmp++;
        if (cyc !== 7) begin
            n_err++;
            $display("FAIL load_latency: got %0d want 7", cyc);
        end
        issue(mk(2'b11, 2'd0, 2'd0, 2'd0, 8'h00, 4'h0));
        tick();
        n_cmp++;
        if (operand1 !== 8'hAA || operand2 !== 8'hAA) begin
            n_err++;
            $display("FAIL load_writeback: got op1=%h op2=%h want aa aa", operand1, operand2);
        end
        wait_idle(n);
    endtask

    task automatic test_store();
        int cyc, wcnt, n;
        do_reset();
        mem_ready = 1'b1;
        result2 = 8'h77;
        issue(mk(2'b11, 2'd3, 2'd1, 2'd0, 8'h20, 4'h0));
        tick();
        cyc = 1;
        n_cmp++;
        if ({operand1, operand2, offset, sel1, sel3, w_r} !== {8'd1, 8'd3, 8'h20, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL store_exec: got op1=%h op2=%h off=%h s1=%b s3=%b wr=%b want 01 03 20 1 1 0",
                     operand1, operand2, offset, sel1, sel3, w_r);
        end
        wcnt = 0;
        while (!instr_ready && cyc < 30) begin
            tick();
            cyc++;
            if (w_r) wcnt++;
        end
        n_cmp++;
        if (wcnt !== 1) begin
            n_err++;
            $display("FAIL store_w_r_cycles: got %0d want 1", wcnt);
        end
        n_cmp++;
        if (cyc !== 3) begin
            n_err++;
            $display("FAIL store_latency: got %0d want 3", cyc);
        end
        n_cmp++;
        if (w_r !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL store_clear: got wr=%b req=%b want 0 0", w_r, mem_req);
        end
        issue(mk(2'b11, 2'd3, 2'd1, 2'd0, 8'h00, 4'h0));
        tick();
        n_cmp++;
        if (operand1 !== 8'd1 || operand2 !== 8'd3) begin
            n_err++;
            $display("FAIL store_no_rf_write: got op1=%h op2=%h want 01 03", operand1, operand2);
        end
        wait_idle(n);
    endtask

    task automatic test_nop_stream();
        int n;
        logic exp_busy;
        do_reset();
        mem_ready = 1'b0;
        result2 = 8'h05;
        issue(mk(2'b01, 2'd1, 2'd2, 2'd3, 8'h05, 4'h2));
        wait_idle(n);
        instr = mk(2'b00, 2'd3, 2'd3, 2'd3, 8'hFF, 4'h7);
        instr_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_busy = ((k % 2) == 1);
            n_cmp++;
            if (busy !== exp_busy) begin
                n_err++;
                $display("FAIL nop_busy[%0d]: got %b want %b", k, busy, exp_busy);
            end
            n_cmp++;
            if ({operand1, operand2, offset, opcode, sel1, sel3} !== {8'd2, 8'd3, 8'h05, 4'h2, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL nop_outputs[%0d]: got op1=%h op2=%h off=%h opc=%h s1=%b s3=%b want 02 03 05 2 1 0",
                         k, operand1, operand2, offset, opcode, sel1, sel3);
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset_in_stall();
        int n;
        do_reset();
        mem_ready = 1'b0;
        result2 = 8'h99;
        issue(mk(2'b01, 2'd3, 2'd0, 2'd0, 8'h00, 4'h0));
        wait_idle(n);
        issue(mk(2'b10, 2'd2, 2'd1, 2'd0, 8'h44, 4'h0));
        tick();
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || w_r !== 1'b0) begin
            n_err++;
            $display("FAIL stall_enter: got req=%b wr=%b want 1 0", mem_req, w_r);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({instr_ready, busy, mem_req, w_r, opcode, operand1, offset} !== {4'b1000, 4'hF, 8'h00, 8'h00}) begin
            n_err++;
            $display("FAIL stall_reset: got rdy=%b busy=%b req=%b wr=%b opc=%h op1=%h off=%h want 1 0 0 0 f 00 00",
                     instr_ready, busy, mem_req, w_r, opcode, operand1, offset);
        end
        mem_ready = 1'b1;
        issue(mk(2'b11, 2'd3, 2'd2, 2'd0, 8'h00, 4'h0));
        tick();
        n_cmp++;
        if (operand1 !== 8'd2 || operand2 !== 8'd3) begin
            n_err++;
            $display("FAIL stall_reset_regs: got op1=%h op2=%h want 02 03", operand1, operand2);
        end
        wait_idle(n);
    endtask

    task automatic test_wide();
        int n;
        do_reset();
        x_mem_ready = 1'b1;
        x_result2 = 16'hBEEF;
        x_instr = mk16(2'b01, 3'd7, 3'd7, 3'd6, 16'h1234, 4'h3);
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        tick();
        n_cmp++;
        if ({x_operand1, x_operand2, x_offset, x_opcode} !== {16'd7, 16'd6, 16'h1234, 4'h3}) begin
            n_err++;
            $display("FAIL wide_exec: got op1=%h op2=%h off=%h opc=%h want 0007 0006 1234 3",
                     x_operand1, x_operand2, x_offset, x_opcode);
        end
        n = 0;
        while (!x_ready && n < 20) begin
            tick();
            n++;
        end
        n_cmp++;
        if (1 + n !== 3) begin
            n_err++;
            $display("FAIL wide_latency: got %0d want 3", 1 + n);
        end
`ifdef CU_PERF_CNT_EN
        n_cmp++;
        if (x_retired !== 32'd1) begin
            n_err++;
            $display("FAIL wide_retired_1: got %0d want 1", x_retired);
        end
`endif
        x_instr = mk16(2'b11, 3'd7, 3'd7, 3'd0, 16'h0000, 4'h0);
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        tick();
        n_cmp++;
        if (x_operand1 !== 16'hBEEF || x_operand2 !== 16'hBEEF || x_sel3 !== 1'b1) begin
            n_err++;
            $display("FAIL wide_reg7: got op1=%h op2=%h s3=%b want beef beef 1", x_operand1, x_operand2, x_sel3);
        end
        n = 0;
        while (!x_ready && n < 20) begin
            tick();
            n++;
        end
`ifdef CU_PERF_CNT_EN
        n_cmp++;
        if (x_retired !== 32'd2) begin
            n_err++;
            $display("FAIL wide_retired_2: got %0d want 2", x_retired);
        end
`endif
    endtask

`ifdef CU_PERF_CNT_EN
    task automatic test_perf();
        int n, mcnt;
        do_reset();
        mem_ready = 1'b0;
        n_cmp++;
        if (retired_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL perf_reset: got ret=%0d stall=%0d want 0 0", retired_cnt, stall_cnt);
        end
        issue(mk(2'b01, 2'd1, 2'd0, 2'd0, 8'h00, 4'h0));
        wait_idle(n);
        issue(mk(2'b00, 2'd0, 2'd0, 2'd0, 8'h00, 4'h0));
        wait_idle(n);
        n_cmp++;
        if (retired_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL perf_retired_2: got %0d want 2", retired_cnt);
        end
        issue(mk(2'b10, 2'd2, 2'd0, 2'd0, 8'h00, 4'h0));
        mcnt = 0;
        n = 0;
        while (!instr_ready && n < 30) begin
            tick();
            n++;
            if (mem_req) begin
                mcnt++;
                if (mcnt == 3) mem_ready = 1'b1;
            end
        end
        n_cmp++;
        if (retired_cnt !== 32'd3 || stall_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL perf_load: got ret=%0d stall=%0d want 3 2", retired_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        result2 = '0;
        mem_ready = 1'b0;
        x_instr = '0;
        x_valid = 1'b0;
        x_result2 = '0;
        x_mem_ready = 1'b0;
        test_reset();
        test_std_op();
        test_load_stall();
        test_store();
        test_nop_stream();
        test_reset_in_stall();
        test_wide();
`ifdef CU_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
